prgrom_load_ctrl: RTL



---
 rtl/cpu_pkg.sv | 14 +
 rtl/rst_pulse_gen.sv | 31 +++
 rtl/prgrom_load_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-ROM load path: state encoding and default sizes.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    RESTART = 2'd3
  } pg_state_e;

  localparam int PRGROM_ADDR_W  = 14;
  localparam int RST_CYCLES_DEF = 4;

endpackage

// File: rtl/rst_pulse_gen.sv
// Loadable down-counter for timed reset pulses; busy while the count is nonzero.
module rst_pulse_gen #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/prgrom_load_ctrl.sv
// Shares the prgrom port between instruction fetch and the UART loader,
// holding the CPU during a load and issuing a timed reset afterwards.
module prgrom_load_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = PRGROM_ADDR_W,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_adr,
  input  logic [31:0]       upg_dat,
  input  logic              upg_done,
  input  logic [31:0]       fetch_addr,
  output logic              rom_en,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              pg_mode,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

  pg_state_e         state_q, state_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0] wr_adr_q, wr_adr_d;
  logic [31:0]       wr_dat_q, wr_dat_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              pulse_load, pulse_busy, pulse_last;

  rst_pulse_gen #(.CNT_W(CNT_W)) u_rst_pulse (
    .clock      (clock),
    .reset      (reset),
    .load_i     (pulse_load),
    .load_val_i (CNT_W'(RST_CYCLES)),
    .busy_o     (pulse_busy),
    .last_o     (pulse_last)
  );

  always_comb begin
    state_d    = state_q;
    wr_vld_d   = 1'b0;
    wr_adr_d   = wr_adr_q;
    wr_dat_d   = wr_dat_q;
    wc_d       = wc_q;
    pulse_load = 1'b0;

    // A pending write retires in whichever cycle the stage is valid.
    if (wr_vld_q && wc_q != WC_MAX)
      wc_d = wc_q + 1'b1;

    unique case (state_q)
      RUN: begin
        if (start_pg) begin
          state_d = LOAD;
          wc_d    = '0;
        end
      end
      LOAD: begin
        wr_vld_d = upg_wen;
        if (upg_wen) begin
          wr_adr_d = upg_adr;
          wr_dat_d = upg_dat;
        end
        if (upg_done) state_d = DRAIN;
      end
      DRAIN: begin
        state_d    = RESTART;
        pulse_load = 1'b1;
      end
      RESTART: begin
        if (pulse_last) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      wr_vld_q <= 1'b0;
      wr_adr_q <= '0;
      wr_dat_q <= '0;
      wc_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_vld_q <= wr_vld_d;
      wr_adr_q <= wr_adr_d;
      wr_dat_q <= wr_dat_d;
      wc_q     <= wc_d;
    end
  end

  // Fetch path stays combinational in RUN so fetch latency is unchanged.
  always_comb begin
    rom_en    = 1'b0;
    rom_we    = 1'b0;
    rom_addr  = wr_adr_q;
    rom_wdata = wr_dat_q;
    unique case (state_q)
      RUN: begin
        rom_en   = 1'b1;
        rom_addr = fetch_addr[ADDR_W+1:2];
      end
      LOAD, DRAIN: begin
        rom_en = wr_vld_q;
        rom_we = wr_vld_q;
      end
      default: ;
    endcase
  end

  assign cpu_hold   = (state_q != RUN);
  assign pg_mode    = (state_q != RUN);
  assign cpu_rst    = (state_q == RESTART);
  assign word_count = wc_q;

  logic unused_sig;
  assign unused_sig = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0], pulse_busy};

endmodule
